serpar_ctrl: RTL and testbench

Sequencer for the serial-to-parallel in/out state buffer of the masked Romulus-N datapath. It accepts one block command at a time, optionally clears the buffer, and then streams exactly 4·d 32-bit share-words into it under a valid/ready handshake. While loading, it drives the per-byte decrypt mask and the output-word handshake. It then optionally hands the state to the TBC core and captures the core result back into the buffer.

---
 rtl/serpar_ctrl_if.sv | 37 +++
 rtl/serpar_ctrl.sv | 103 ++++++++++
 tb/tb_serpar_ctrl.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/serpar_ctrl_if.sv
// Handshake and strobe bundle between the serial/parallel state buffer sequencer and its environment.
interface serpar_ctrl_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_clr;
    logic       cmd_msg;
    logic       cmd_dec;
    logic       cmd_run;
    logic       pdi_valid;
    logic       pdi_ready;
    logic [2:0] pdi_bytes;
    logic       pdo_valid;
    logic       pdo_ready;
    logic       buf_rst;
    logic       buf_wr;
    logic       buf_en;
    logic [3:0] buf_decrypt;
    logic       core_start;
    logic       core_done;
    logic       blk_done;

    // Environment side: issues commands, supplies words, consumes output, runs the core.
    modport master (
        output cmd_valid, cmd_clr, cmd_msg, cmd_dec, cmd_run,
        output pdi_valid, pdi_bytes, pdo_ready, core_done,
        input  cmd_ready, pdi_ready, pdo_valid,
        input  buf_rst, buf_wr, buf_en, buf_decrypt, core_start, blk_done
    );

    // Controller side.
    modport slave (
        input  cmd_valid, cmd_clr, cmd_msg, cmd_dec, cmd_run,
        input  pdi_valid, pdi_bytes, pdo_ready, core_done,
        output cmd_ready, pdi_ready, pdo_valid,
        output buf_rst, buf_wr, buf_en, buf_decrypt, core_start, blk_done
    );
endinterface

// File: rtl/serpar_ctrl.sv
// Sequencer for the masked Romulus-N serial/parallel state buffer:
// optional clear, 4*D share-word load, optional core run and result capture.
module serpar_ctrl #(
    parameter int unsigned D = 2
) (
    input logic         clk,
    input logic         rst_n,
    serpar_ctrl_if.slave bus
);
    localparam int unsigned WORDS = 4 * D;
    localparam int unsigned CNT_W = $clog2(WORDS) + 1;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        CLR  = 3'd1,
        LOAD = 3'd2,
        CORE = 3'd3,
        CAPT = 3'd4
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             clr_q;
    logic             msg_q;
    logic             dec_q;
    logic             run_q;
    logic             first_q;
    logic [2:0]       eff_bytes;
    logic             load;
    logic             wr;
    logic             last_wr;

    // Handshake and strobe decode; load-phase outputs follow the live inputs.
    always_comb begin
        eff_bytes       = (bus.pdi_bytes == 3'd0 || bus.pdi_bytes > 3'd4) ? 3'd4 : bus.pdi_bytes;
        load            = (state_q == LOAD);
        bus.cmd_ready   = (state_q == IDLE);
        bus.pdi_ready   = load & (~msg_q | bus.pdo_ready);
        bus.pdo_valid   = load & msg_q & bus.pdi_valid;
        wr              = bus.pdi_valid & bus.pdi_ready;
        bus.buf_wr      = wr;
        last_wr         = wr & (cnt_q == CNT_W'(WORDS - 1));
        cnt_d           = wr ? cnt_q + CNT_W'(1) : cnt_q;
        bus.buf_rst     = (state_q == CLR) & clr_q;
        bus.buf_en      = (state_q == CAPT);
        bus.core_start  = (state_q == CORE) & first_q;
        bus.blk_done    = (last_wr & ~run_q) | (state_q == CAPT);
        bus.buf_decrypt = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            bus.buf_decrypt[i] = load & dec_q & msg_q & (3'(i) < eff_bytes);
        end
    end

    // State, word counter and latched command fields.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            clr_q   <= 1'b0;
            msg_q   <= 1'b0;
            dec_q   <= 1'b0;
            run_q   <= 1'b0;
            first_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (bus.cmd_valid) begin
                        clr_q   <= bus.cmd_clr;
                        msg_q   <= bus.cmd_msg;
                        dec_q   <= bus.cmd_dec;
                        run_q   <= bus.cmd_run;
                        state_q <= bus.cmd_clr ? CLR : LOAD;
                    end
                end
                CLR: begin
                    state_q <= LOAD;
                end
                LOAD: begin
                    cnt_q <= cnt_d;
                    if (last_wr) begin
                        state_q <= run_q ? CORE : IDLE;
                        first_q <= run_q;
                    end
                end
                CORE: begin
                    // core_done in the launch cycle is stale and deliberately ignored
                    first_q <= 1'b0;
                    if (!first_q && bus.core_done) begin
                        state_q <= CAPT;
                    end
                end
                CAPT: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serpar_ctrl.sv
// Scoreboard bench for serpar_ctrl: driver models the block protocol, monitor compares at negedge.
module tb_serpar_ctrl;
    localparam int unsigned D     = 2;
    localparam int unsigned WORDS = 4 * D;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    serpar_ctrl_if bus ();
    serpar_ctrl #(.D(D)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    // Per-cycle expectation: {cmd_ready,pdi_ready,pdo_valid,buf_rst,buf_wr,buf_en,core_start,blk_done,decrypt[3:0]}
    logic [11:0] ctl_exp;
    bit          ctl_en;
    bit          chk_empty;
    bit          mon_on;
    string       phase;
    int          n_tests;
    int          n_fail;

    typedef struct { logic [3:0] mask; int idx; } sb_t;
    sb_t sb_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    // Monitor: per-cycle control comparison plus scoreboard pop on every buffer write.
    always @(negedge clk) begin
        if (mon_on) begin
            if (ctl_en) begin
                chk(phase, 32'({bus.cmd_ready, bus.pdi_ready, bus.pdo_valid, bus.buf_rst, bus.buf_wr,
                                bus.buf_en, bus.core_start, bus.blk_done, bus.buf_decrypt}), 32'(ctl_exp));
            end
            if (bus.buf_wr) begin
                if (sb_q.size() == 0) begin
                    chk("sb_underflow", 32'(1), 32'(0));
                end else begin
                    sb_t e;
                    e = sb_q.pop_front();
                    chk($sformatf("word%0d_decrypt", e.idx), 32'(bus.buf_decrypt), 32'(e.mask));
                end
            end
            if (chk_empty) chk("sb_leftover", 32'(sb_q.size()), 32'(0));
        end
    end

    function automatic logic [3:0] exp_mask(input bit msg, input bit dec, input logic [2:0] b);
        int eff;
        eff = (b == 3'd0 || b > 3'd4) ? 4 : int'(b);
        return (msg && dec) ? 4'((1 << eff) - 1) : 4'b0000;
    endfunction

    function automatic logic [2:0] pick_bytes(input int bmode, input int n);
        case (bmode)
            0:       return (n == WORDS - 1) ? 3'd2 : 3'd4;
            1:       return 3'($urandom_range(0, 7));
            default: return 3'd0;
        endcase
    endfunction

    task automatic set_ctl(input string p, input bit cr, input bit pr, input bit pv, input bit rs,
                           input bit wr, input bit en, input bit cs, input bit bd, input logic [3:0] dm);
        phase   = p;
        ctl_en  = 1'b1;
        ctl_exp = {cr, pr, pv, rs, wr, en, cs, bd, dm};
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // mode: 0 all ready, 1 random, 2 pdo_ready toggles, 3 pdi_valid 1,0,0 with a stray cmd_valid
    task automatic do_block(input bit clr, input bit msg, input bit dec, input bit run, input int mode,
                            input int bmode, input int gap, input bit done_in_start, input int kill_at);
        int n;
        int k;
        bit wr;
        logic [2:0] cur;
        next_cycle();
        bus.cmd_valid = 1'b1;
        bus.cmd_clr = clr; bus.cmd_msg = msg; bus.cmd_dec = dec; bus.cmd_run = run;
        set_ctl("accept", 1, 0, 0, 0, 0, 0, 0, 0, 4'b0);
        next_cycle();
        bus.cmd_valid = 1'b0;
        bus.cmd_clr = 1'($urandom); bus.cmd_msg = 1'($urandom);
        bus.cmd_dec = 1'($urandom); bus.cmd_run = 1'($urandom);
        if (clr) begin
            bus.pdi_valid = (mode == 0);
            set_ctl("clear", 0, 0, 0, 1, 0, 0, 0, 0, 4'b0);
            next_cycle();
        end
        n = 0;
        k = 0;
        cur = pick_bytes(bmode, 0);
        sb_q.push_back('{exp_mask(msg, dec, cur), 1});
        while (n < WORDS && k < 500) begin
            case (mode)
                0:       begin bus.pdi_valid = 1'b1; bus.pdo_ready = 1'b1; end
                1:       begin bus.pdi_valid = 1'($urandom); bus.pdo_ready = 1'($urandom); end
                2:       begin bus.pdi_valid = 1'b1; bus.pdo_ready = (k % 2 == 0); end
                default: begin bus.pdi_valid = (k % 3 == 0); bus.pdo_ready = 1'b1; end
            endcase
            bus.pdi_bytes = cur;
            bus.core_done = (mode == 1) ? 1'($urandom) : 1'b0;
            bus.cmd_valid = (mode == 3 && k == 2);
            wr = bus.pdi_valid && (!msg || bus.pdo_ready);
            set_ctl("load", 0, !msg || bus.pdo_ready, msg && bus.pdi_valid, 0, wr, 0, 0,
                    wr && n == WORDS - 1 && !run, exp_mask(msg, dec, cur));
            k++;
            next_cycle();
            bus.cmd_valid = 1'b0;
            if (wr) begin
                n++;
                if (n == kill_at) begin
                    bus.pdi_valid = 1'b0;
                    rst_n = 1'b0;
                    set_ctl("rst_hold", 0, !msg || bus.pdo_ready, 0, 0, 0, 0, 0, 0, exp_mask(msg, dec, cur));
                    next_cycle();
                    rst_n = 1'b1;
                    set_ctl("after_rst", 1, 0, 0, 0, 0, 0, 0, 0, 4'b0);
                    return;
                end
                if (n < WORDS) begin
                    cur = pick_bytes(bmode, n);
                    sb_q.push_back('{exp_mask(msg, dec, cur), n + 1});
                end
            end
        end
        bus.pdi_valid = 1'b0;
        bus.pdo_ready = 1'b0;
        bus.core_done = 1'b0;
        if (!run) begin
            set_ctl("idle_after", 1, 0, 0, 0, 0, 0, 0, 0, 4'b0);
            return;
        end
        bus.core_done = done_in_start;
        set_ctl("core_start", 0, 0, 0, 0, 0, 0, 1, 0, 4'b0);
        next_cycle();
        bus.core_done = 1'b0;
        for (int g = 0; g < gap; g++) begin
            set_ctl("core_wait", 0, 0, 0, 0, 0, 0, 0, 0, 4'b0);
            next_cycle();
        end
        bus.core_done = 1'b1;
        set_ctl("core_done", 0, 0, 0, 0, 0, 0, 0, 0, 4'b0);
        next_cycle();
        bus.core_done = 1'b0;
        set_ctl("capture", 0, 0, 0, 0, 0, 1, 0, 1, 4'b0);
        next_cycle();
        set_ctl("idle_after", 1, 0, 0, 0, 0, 0, 0, 0, 4'b0);
    endtask

    initial begin
        n_tests = 0; n_fail = 0;
        ctl_en = 1'b0; chk_empty = 1'b0; mon_on = 1'b0; ctl_exp = '0; phase = "none";
        bus.cmd_valid = 1'b0; bus.cmd_clr = 1'b0; bus.cmd_msg = 1'b0; bus.cmd_dec = 1'b0;
        bus.cmd_run = 1'b0; bus.pdi_valid = 1'b0; bus.pdi_bytes = 3'd4; bus.pdo_ready = 1'b0;
        bus.core_done = 1'b0;
        rst_n = 1'b0;
        repeat (2) next_cycle();
        rst_n = 1'b1;
        mon_on = 1'b1;
        set_ctl("reset", 1, 0, 0, 0, 0, 0, 0, 0, 4'b0);

        do_block(1, 0, 0, 1, 0, 0, 2, 0, 0);   // clear + load + core, core_done three cycles after start
        do_block(0, 1, 0, 0, 2, 1, 0, 0, 0);   // encrypt with pdo back-pressure
        do_block(0, 1, 1, 0, 0, 0, 0, 0, 0);   // decrypt, short last word
        do_block(0, 1, 1, 0, 0, 2, 0, 0, 0);   // decrypt, pdi_bytes 0 means full word
        do_block(0, 0, 0, 0, 3, 1, 0, 0, 0);   // pdi_valid gaps and stray command
        do_block(0, 0, 0, 1, 0, 1, 3, 1, 0);   // stale core_done in launch cycle
        do_block(0, 1, 1, 1, 1, 1, 0, 0, 5);   // reset after five writes
        do_block(1, 0, 0, 0, 0, 1, 0, 0, 0);   // full reload after reset
        for (int r = 0; r < 12; r++) begin
            do_block(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 3),
                     1, $urandom_range(0, 4), 1'($urandom), 0);
        end

        next_cycle();
        chk_empty = 1'b1;
        @(negedge clk);
        #1;
        chk_empty = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
